// File: rtl/muldiv_ctrl_if.sv
// EX-stage handshake bundle between the pipeline and the M-extension multiply/divide unit.
interface muldiv_ctrl_if #(
  parameter int BIT_W = 32
);
  logic             start_i;
  logic [2:0]       op_i;
  logic [BIT_W-1:0] rs1_i;
  logic [BIT_W-1:0] rs2_i;
  logic [4:0]       rd_i;
  logic             flush_i;
  logic             stall_o;
  logic             busy_o;
  logic             done_o;
  logic [BIT_W-1:0] result_o;
  logic [4:0]       rd_o;

  modport master (
    output start_i, op_i, rs1_i, rs2_i, rd_i, flush_i,
    input  stall_o, busy_o, done_o, result_o, rd_o
  );

  modport slave (
    input  start_i, op_i, rs1_i, rs2_i, rd_i, flush_i,
    output stall_o, busy_o, done_o, result_o, rd_o
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// RV32M multiply/divide sequencer: single-cycle multiply, iterative restoring divider.
// Divider compiled in only when MULDIV_DIV_EN is defined; otherwise op>=4 returns 0 with multiply timing.
//
// state | meaning
// IDLE  | waiting for start_i
// MUL   | one-cycle product of latched operands
// DIV   | restoring division, one quotient bit per cycle (or one-cycle bypass)
// DONE  | done_o high, result_o/rd_o valid
module muldiv_ctrl #(
  parameter int BIT_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state;
  logic [2:0]       op_q;
  logic [BIT_W-1:0] rs1_q;
  logic [BIT_W-1:0] rs2_q;
  logic [4:0]       rd_q;
  logic             done_q;
  logic [BIT_W-1:0] result_q;
  logic [4:0]       rd_out_q;

  logic             rs1_signed;
  logic             rs2_signed;
  logic [2*BIT_W-1:0] mul_a;
  logic [2*BIT_W-1:0] mul_b;
  logic [2*BIT_W-1:0] mul_prod;
  logic [BIT_W-1:0] mul_res;

  assign rs1_signed = (op_q == 3'd0) || (op_q == 3'd1) || (op_q == 3'd2);
  assign rs2_signed = (op_q == 3'd0) || (op_q == 3'd1);
  assign mul_a      = {{BIT_W{rs1_signed & rs1_q[BIT_W-1]}}, rs1_q};
  assign mul_b      = {{BIT_W{rs2_signed & rs2_q[BIT_W-1]}}, rs2_q};
  assign mul_prod   = mul_a * mul_b;

  // op>=4 only lands here when the divider is not built; it then yields 0.
  always_comb begin
    mul_res = '0;
    if (op_q == 3'd0)
      mul_res = mul_prod[BIT_W-1:0];
    else if (!op_q[2])
      mul_res = mul_prod[2*BIT_W-1:BIT_W];
  end

`ifdef MULDIV_DIV_EN
  localparam int CNT_W = $clog2(BIT_W + 1);

  logic [CNT_W-1:0] cnt;
  logic [BIT_W-1:0] quot;
  logic [BIT_W-1:0] rem;
  logic             div_signed;
  logic             is_rem;
  logic [BIT_W-1:0] divisor_mag;
  logic [BIT_W:0]   rem_shift;
  logic [BIT_W:0]   rem_diff;
  logic             step_ge;
  logic [BIT_W-1:0] quot_nxt;
  logic [BIT_W-1:0] rem_nxt;
  logic [BIT_W-1:0] q_fix;
  logic [BIT_W-1:0] r_fix;
  logic             div_zero;
  logic             div_ovf;
  logic             div_last;
  logic [BIT_W-1:0] div_res;

  assign div_signed  = ~op_q[0];
  assign is_rem      = op_q[1];
  assign divisor_mag = (div_signed & rs2_q[BIT_W-1]) ? -rs2_q : rs2_q;

  // Partial remainder stays below the divisor, so a (BIT_W+1)-bit difference never wraps.
  assign rem_shift = {rem, quot[BIT_W-1]};
  assign rem_diff  = rem_shift - {1'b0, divisor_mag};
  assign step_ge   = ~rem_diff[BIT_W];
  assign quot_nxt  = {quot[BIT_W-2:0], step_ge};
  assign rem_nxt   = step_ge ? rem_diff[BIT_W-1:0] : rem_shift[BIT_W-1:0];

  assign q_fix = (div_signed & (rs1_q[BIT_W-1] ^ rs2_q[BIT_W-1])) ? -quot_nxt : quot_nxt;
  assign r_fix = (div_signed & rs1_q[BIT_W-1]) ? -rem_nxt : rem_nxt;

  assign div_zero = (rs2_q == '0);
  assign div_ovf  = div_signed && (rs1_q == {1'b1, {(BIT_W-1){1'b0}}}) && (&rs2_q);
  assign div_last = div_zero || div_ovf || (cnt == CNT_W'(1));

  always_comb begin
    div_res = is_rem ? r_fix : q_fix;
    if (div_zero)
      div_res = is_rem ? rs1_q : '1;
    else if (div_ovf)
      div_res = is_rem ? '0 : rs1_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
`ifdef MULDIV_DIV_EN
      cnt      <= '0;
      quot     <= '0;
      rem      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i && !bus.flush_i) begin
            op_q  <= bus.op_i;
            rs1_q <= bus.rs1_i;
            rs2_q <= bus.rs2_i;
            rd_q  <= bus.rd_i;
`ifdef MULDIV_DIV_EN
            if (bus.op_i[2]) begin
              state <= DIV;
              cnt   <= CNT_W'(BIT_W);
              rem   <= '0;
              quot  <= (!bus.op_i[0] && bus.rs1_i[BIT_W-1]) ? -bus.rs1_i : bus.rs1_i;
            end else begin
              state <= MUL;
            end
`else
            state <= MUL;
`endif
          end
        end
        MUL: begin
          if (bus.flush_i) begin
            state <= IDLE;
          end else begin
            result_q <= mul_res;
            rd_out_q <= rd_q;
            done_q   <= 1'b1;
            state    <= DONE;
          end
        end
`ifdef MULDIV_DIV_EN
        DIV: begin
          if (bus.flush_i) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (div_last) begin
            result_q <= div_res;
            rd_out_q <= rd_q;
            done_q   <= 1'b1;
            cnt      <= '0;
            state    <= DONE;
          end else begin
            quot <= quot_nxt;
            rem  <= rem_nxt;
            cnt  <= cnt - CNT_W'(1);
          end
        end
`endif
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.stall_o  = !rst && (((state == IDLE) && bus.start_i && !bus.flush_i) ||
                                 (state == MUL) || (state == DIV));
  assign bus.busy_o   = (state != IDLE);
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;
  assign bus.rd_o     = rd_out_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized self-checking bench for muldiv_ctrl against an arithmetic reference of RV32M semantics.
module tb_muldiv_ctrl;
  localparam int BIT_W = 32;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  muldiv_ctrl_if #(.BIT_W(BIT_W)) bus ();

  muldiv_ctrl #(.BIT_W(BIT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // RV32M result and done latency (cycles after accept) from the instruction semantics.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    longint sa;
    longint sb;
    logic [63:0] p;
    int da;
    int db;
    bit ovf;
    res = '0;
    lat = 2;
    if (op < 3'd4) begin
      sa  = (op <= 3'd2) ? longint'($signed(a)) : longint'({32'b0, a});
      sb  = (op <= 3'd1) ? longint'($signed(b)) : longint'({32'b0, b});
      p   = 64'(sa * sb);
      res = (op == 3'd0) ? p[31:0] : p[63:32];
    end else begin
`ifdef MULDIV_DIV_EN
      da  = $signed(a);
      db  = $signed(b);
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
        3'd4: res = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(da / db);
        3'd5: res = (b == 0) ? 32'hFFFF_FFFF : a / b;
        3'd6: res = (b == 0) ? a : ovf ? 32'h0 : 32'(da % db);
        default: res = (b == 0) ? a : a % b;
      endcase
      lat = ((b == 0) || (ovf && !op[0])) ? 2 : BIT_W + 1;
`else
      res = '0;
      lat = 2;
`endif
    end
  endtask

  // Entered right after a rising edge; flush_at>0 kills the op in that cycle after accept.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int flush_at, input string tag);
    logic [31:0] res;
    int lat;
    bit seen;
    model(op, a, b, res, lat);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.rs1_i   = a;
    bus.rs2_i   = b;
    bus.rd_i    = rd;
    bus.flush_i = 1'b0;
    #1 chk({tag, "_stall_acc"}, 32'(bus.stall_o), 32'd1);
    @(posedge clk); #1;
    seen = 1'b0;
    for (int k = 1; k <= BIT_W + 8 && !seen; k++) begin
      if (bus.done_o) begin
        seen = 1'b1;
        bus.start_i = 1'b0;
        chk({tag, "_lat"}, 32'(k), 32'(lat));
        chk({tag, "_res"}, bus.result_o, res);
        chk({tag, "_rd"}, 32'(bus.rd_o), 32'(rd));
        #1 chk({tag, "_stall_done"}, 32'(bus.stall_o), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(bus.done_o), 32'd0);
        chk({tag, "_hold"}, bus.result_o, res);
        chk({tag, "_idle"}, 32'(bus.busy_o), 32'd0);
      end else if (k == flush_at) begin
        seen = 1'b1;
        bus.flush_i = 1'b1;
        bus.start_i = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        bus.start_i = 1'b0;
        #1;
        chk({tag, "_fl_busy"}, 32'(bus.busy_o), 32'd0);
        chk({tag, "_fl_stall"}, 32'(bus.stall_o), 32'd0);
        chk({tag, "_fl_done"}, 32'(bus.done_o), 32'd0);
      end else begin
        if (k == 1) chk({tag, "_stall_busy"}, 32'(bus.stall_o), 32'd1);
        // Noise on the inputs while busy: must be ignored and must not disturb latched operands.
        bus.start_i = 1'($urandom_range(0, 1));
        bus.op_i    = 3'($urandom);
        bus.rs1_i   = $urandom;
        bus.rs2_i   = $urandom;
        bus.rd_i    = 5'($urandom);
        @(posedge clk); #1;
      end
    end
    if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
    bus.start_i = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int flush_far;
    int rst_at;
    n_vec = 0;
    n_err = 0;
`ifdef MULDIV_DIV_EN
    flush_far = 10;
    rst_at    = 5;
`else
    flush_far = 1;
    rst_at    = 1;
`endif
    rst         = 1'b1;
    bus.start_i = 1'b1;
    bus.op_i    = 3'd0;
    bus.rs1_i   = 32'd9;
    bus.rs2_i   = 32'd9;
    bus.rd_i    = 5'd1;
    bus.flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(bus.stall_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    chk("rst_result", bus.result_o, 32'd0);
    chk("rst_rd", 32'(bus.rd_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.start_i = 1'b0;
    chk("rst_no_accept", 32'(bus.busy_o), 32'd0);

    run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3, 0, "mulh");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 0, "div_neg");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5, 0, "rem_neg");
    run_op(3'd5, 32'd5, 32'd0, 5'd6, 0, "divu_z");
    run_op(3'd7, 32'd5, 32'd0, 5'd7, 0, "remu_z");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 0, "rem_ovf");
    run_op(3'd5, 32'h1234_5678, 32'd3, 5'd10, flush_far, "flush");
    run_op(3'd0, 32'd3, 32'd4, 5'd11, 0, "mul_after_flush");

    // Reset mid-operation with start_i held high throughout.
    bus.start_i = 1'b1;
    bus.op_i    = 3'd5;
    bus.rs1_i   = 32'hDEAD_BEEF;
    bus.rs2_i   = 32'd3;
    bus.rd_i    = 5'd12;
    @(posedge clk); #1;
    repeat (rst_at - 1) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_stall", 32'(bus.stall_o), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy_o), 32'd0);
    chk("mid_rst_done", 32'(bus.done_o), 32'd0);
    chk("mid_rst_result", bus.result_o, 32'd0);
    chk("mid_rst_rd", 32'(bus.rd_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.start_i = 1'b0;
    chk("mid_rst_no_accept", 32'(bus.busy_o), 32'd0);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 5'($urandom),
             ($urandom_range(0, 7) == 0) ? 1 : 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
